// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry elastic pipeline register (main + skid) with flush
//
// Ports:
//   clk        rising-edge clock
//   r          synchronous reset, active-high, highest priority
//   in_valid   upstream payload valid
//   in_data    upstream payload
//   in_ready   stage can accept a payload (registered state only)
//   out_valid  main entry holds a valid payload
//   out_data   main entry payload, straight from the main register
//   out_ready  downstream accepts out_data this cycle
//   flush      synchronous squash of all held entries
//   occupancy  number of valid entries (0..2)

module pipe_skid_en_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (r) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

module pipe_skid_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             r,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [1:0]       occupancy
);
    // Encoding chosen so the state value is the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL1 = 2'd1,
        FULL2 = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic [WIDTH-1:0] main_d;
    logic             skid_en;

    assign in_ready  = (state != FULL2);
    assign out_valid = (state != EMPTY);
    assign occupancy = state;
    assign out_data  = main_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Data enables are suppressed on flush: held data stays, nothing new loads.
    always_comb begin
        main_en = 1'b0;
        main_d  = in_data;
        skid_en = 1'b0;
        if (!flush) begin
            unique case (state)
                EMPTY: main_en = in_fire;
                FULL1: begin
                    main_en = in_fire & out_fire;
                    skid_en = in_fire & ~out_fire;
                end
                FULL2: begin
                    main_en = out_fire;
                    main_d  = skid_q;
                end
                default: begin
                    main_en = 1'b0;
                    skid_en = 1'b0;
                end
            endcase
        end
    end

    pipe_skid_en_reg #(.WIDTH(WIDTH)) u_main (
        .clk (clk),
        .r   (r),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_skid_en_reg #(.WIDTH(WIDTH)) u_skid (
        .clk (clk),
        .r   (r),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

    always_ff @(posedge clk) begin
        if (r || flush) begin
            state <= EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (in_fire) state <= FULL1;
                FULL1: begin
                    if (in_fire && !out_fire) begin
                        state <= FULL2;
                    end else if (!in_fire && out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL2: if (out_fire) state <= FULL1;
                default: state <= EMPTY;
            endcase
        end
    end
endmodule
